// File: rtl/sha256_compress_ctrl.sv
// Sequenced SHA-256 compression: one 512-bit block, 64 rounds at one per cycle,
// folded into a persistent chaining hash state.

module sha256_ch (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  output logic [31:0] res_c
);
  assign res_c = (x & y) ^ (~x & z);
endmodule

module sha256_maj (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  output logic [31:0] res_c
);
  assign res_c = (x & y) ^ (x & z) ^ (y & z);
endmodule

module sha256_compress_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         init,
  input  logic [511:0] block,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ROUNDS = 64;
  localparam int unsigned WIN    = 16;
  localparam int unsigned T_W    = 6;

  localparam logic [WORD_W-1:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K_ROM [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t            state_q, state_d;
  logic              accept_c;
  logic [T_W-1:0]    t_q;
  logic [WORD_W-1:0] hs_q [8];
  logic [WORD_W-1:0] wv_q [8];
  logic [WORD_W-1:0] w_q  [WIN];
  logic              busy_q, done_q;

  logic [WORD_W-1:0] ch_c, maj_c, t1_c, t2_c, w_new_c;

  sha256_ch  u_ch  (.x(wv_q[4]), .y(wv_q[5]), .z(wv_q[6]), .res_c(ch_c));
  sha256_maj u_maj (.x(wv_q[0]), .y(wv_q[1]), .z(wv_q[2]), .res_c(maj_c));

  // Round datapath and schedule expansion; w_q[0] is always W_t.
  always_comb begin
    t1_c    = wv_q[7] + bsig1(wv_q[4]) + ch_c + K_ROM[t_q] + w_q[0];
    t2_c    = bsig0(wv_q[0]) + maj_c;
    w_new_c = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == FINAL);
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD:  state_d = ROUND;
      ROUND: if (t_q == T_W'(ROUNDS - 1)) state_d = FINAL;
      FINAL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= '0;
      for (int i = 0; i < 8; i++) begin
        hs_q[i] <= IV[i];
        wv_q[i] <= '0;
      end
      for (int i = 0; i < WIN; i++) w_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            for (int i = 0; i < WIN; i++) w_q[i] <= block[511 - 32*i -: 32];
            if (init) for (int i = 0; i < 8; i++) hs_q[i] <= IV[i];
          end
        end
        LOAD: begin
          for (int i = 0; i < 8; i++) wv_q[i] <= hs_q[i];
          t_q <= '0;
        end
        ROUND: begin
          wv_q[7] <= wv_q[6];
          wv_q[6] <= wv_q[5];
          wv_q[5] <= wv_q[4];
          wv_q[4] <= wv_q[3] + t1_c;
          wv_q[3] <= wv_q[2];
          wv_q[2] <= wv_q[1];
          wv_q[1] <= wv_q[0];
          wv_q[0] <= t1_c + t2_c;
          for (int i = 0; i < WIN - 1; i++) w_q[i] <= w_q[i+1];
          w_q[WIN-1] <= w_new_c;
          t_q <= t_q + T_W'(1);
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) hs_q[i] <= hs_q[i] + wv_q[i];
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign digest = {hs_q[0], hs_q[1], hs_q[2], hs_q[3], hs_q[4], hs_q[5], hs_q[6], hs_q[7]};

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Directed bench for sha256_compress_ctrl: known-answer blocks, chaining,
// ignored starts and asynchronous abort.

module tb_sha256_compress_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         init;
  logic [511:0] block;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] IV_D    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_D   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_D   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] ABC_B   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
  localparam logic [511:0] TB1_B   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TB2_B   = {480'h0, 32'h000001c0};

  typedef struct {
    logic [511:0] blk;
    logic         ini;
    logic         chk;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [5];

  sha256_compress_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .init(init), .block(block),
    .busy(busy), .done(done), .digest(digest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one block from the current cycle; returns the cycle done appeared in.
  task automatic run_block(input logic [511:0] blk, input logic ini, input int g1, input int g2,
                           output int dcyc, output int busy_bad);
    dcyc     = -1;
    busy_bad = 0;
    block = blk;
    init  = ini;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    init  = 1'b0;
    block = ~blk;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        dcyc = n;
        break;
      end
      if (!busy) busy_bad++;
      if (n == g1 || n == g2) begin
        start = 1'b1;
        init  = 1'b1;
        block = EMPTY_B;
      end else begin
        start = 1'b0;
        init  = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    init  = 1'b0;
  endtask

  task automatic check_run(input string name, input int dcyc, input int busy_bad);
    check({name, ".done_cycle"}, 256'(dcyc), 256'd67);
    check({name, ".busy_profile"}, 256'(busy_bad), 256'd0);
    check({name, ".busy_at_done"}, 256'(busy), 256'd0);
  endtask

  initial begin
    int dcyc, bb, ndone;
    vecs[0] = '{blk: ABC_B,   ini: 1'b1, chk: 1'b1, exp: ABC_D};
    vecs[1] = '{blk: ABC_B,   ini: 1'b1, chk: 1'b1, exp: ABC_D};
    vecs[2] = '{blk: EMPTY_B, ini: 1'b1, chk: 1'b1, exp: EMPTY_D};
    vecs[3] = '{blk: TB1_B,   ini: 1'b1, chk: 1'b0, exp: '0};
    vecs[4] = '{blk: TB2_B,   ini: 1'b0, chk: 1'b1, exp: TWO_D};

    rst   = 1'b1;
    start = 1'b0;
    init  = 1'b0;
    block = '0;
    #12;
    check("reset.busy", 256'(busy), 256'd0);
    check("reset.done", 256'(done), 256'd0);
    check("reset.digest", digest, IV_D);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Consecutive blocks, each started in the done cycle of the previous one.
    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i].blk, vecs[i].ini, -1, -1, dcyc, bb);
      check_run($sformatf("vec%0d", i), dcyc, bb);
      if (vecs[i].chk) check($sformatf("vec%0d.digest", i), digest, vecs[i].exp);
    end

    init = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("init_no_start.digest", digest, TWO_D);
    check("init_no_start.busy", 256'(busy), 256'd0);
    init = 1'b0;

    run_block(ABC_B, 1'b1, 10, 40, dcyc, bb);
    check_run("glitch", dcyc, bb);
    check("glitch.digest", digest, ABC_D);
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("glitch.extra_done", 256'(ndone), 256'd0);
    check("glitch.digest_hold", digest, ABC_D);

    // Abort during round t=30 (cycle 32) with an asynchronous mid-cycle reset.
    block = ABC_B;
    init  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    init  = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    check("abort.busy_before", 256'(busy), 256'd1);
    #3;
    rst = 1'b1;
    #1;
    check("abort.busy", 256'(busy), 256'd0);
    check("abort.done", 256'(done), 256'd0);
    check("abort.digest", digest, IV_D);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_block(ABC_B, 1'b1, -1, -1, dcyc, bb);
    check_run("after_abort", dcyc, bb);
    check("after_abort.digest", digest, ABC_D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
